uart_deframe: RTL and testbench

UART_DEFRAME -- requirements
Module: uart_deframe

---
 rtl/uart_deframe_if.sv | 23 ++
 rtl/uart_deframe.sv | 120 ++++++++++++
 tb/tb_uart_deframe.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_deframe_if.sv
// uart_deframe_if: frame-in / byte-out handshake bundle between the receiver, the deframer and its consumer
interface uart_deframe_if;
    logic        recieved_flag;
    logic [10:0] data_parll;
    logic        err_clr;
    logic        data_ready;
    logic        data_valid;
    logic [7:0]  data_out;
    logic        parity_err;
    logic        frame_err;
    logic        overrun;
    logic [3:0]  fifo_count;

    modport master (
        output recieved_flag, data_parll, err_clr, data_ready,
        input  data_valid, data_out, parity_err, frame_err, overrun, fifo_count
    );

    modport slave (
        input  recieved_flag, data_parll, err_clr, data_ready,
        output data_valid, data_out, parity_err, frame_err, overrun, fifo_count
    );
endinterface

// File: rtl/uart_deframe.sv
// uart_deframe: checks received UART frames for parity/framing errors and queues {fe, pe, byte} in a small FIFO
module uart_deframe #(
    parameter int PARITY_ODD = 0,
    parameter int FIFO_DEPTH = 4
) (
    input logic          baud_clk,
    input logic          rst,
    uart_deframe_if.slave bus
);
    localparam int   AW    = $clog2(FIFO_DEPTH);
    localparam logic P_ODD = 1'(PARITY_ODD);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_PUSH} state_t;

    state_t        r_state, w_next;
    logic          r_flag_d;
    logic          r_armed;
    logic [10:0]   r_frame;
    logic [7:0]    r_byte;
    logic          r_pe;
    logic          r_fe;
    logic [9:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [3:0]    r_count;
    logic          r_overrun;
    logic          w_rise;
    logic          w_latch;
    logic          w_check;
    logic          w_in_push;
    logic          w_valid;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_ovr_evt;
    logic [9:0]    w_head;

    // r_armed stays low after reset until the flag is seen low, so a flag already high at release is ignored
    assign w_rise    = bus.recieved_flag & ~r_flag_d & r_armed;
    assign w_in_push = (r_state == S_PUSH);
    assign w_valid   = (r_count != 4'd0);
    assign w_full    = (r_count == 4'(FIFO_DEPTH));
    assign w_pop     = w_valid & bus.data_ready;
    assign w_push    = w_in_push & (~w_full | w_pop);
    assign w_ovr_evt = (w_in_push & w_full & ~w_pop) | (w_rise & (r_state != S_IDLE));
    assign w_head    = r_mem[r_rd];

    assign bus.data_valid = w_valid;
    assign bus.data_out   = w_valid ? w_head[7:0] : 8'd0;
    assign bus.parity_err = w_valid ? w_head[8] : 1'b0;
    assign bus.frame_err  = w_valid ? w_head[9] : 1'b0;
    assign bus.overrun    = r_overrun;
    assign bus.fifo_count = r_count;

    // FSM state register
    always_ff @(posedge baud_clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // FSM next state: capture in IDLE, evaluate in CHECK, enqueue in PUSH
    always_comb begin
        w_next  = r_state;
        w_latch = 1'b0;
        w_check = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_latch = w_rise;
                w_next  = w_rise ? S_CHECK : S_IDLE;
            end
            S_CHECK: begin
                w_check = 1'b1;
                w_next  = S_PUSH;
            end
            S_PUSH:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // edge detect, frame capture and error evaluation
    always_ff @(posedge baud_clk) begin
        if (rst) begin
            r_flag_d <= 1'b0;
            r_armed  <= 1'b0;
            r_frame  <= 11'd0;
            r_byte   <= 8'd0;
            r_pe     <= 1'b0;
            r_fe     <= 1'b0;
        end else begin
            r_flag_d <= bus.recieved_flag;
            r_armed  <= r_armed | ~bus.recieved_flag;
            if (w_latch) r_frame <= bus.data_parll;
            if (w_check) begin
                r_pe   <= (^r_frame[9:1]) ^ P_ODD;
                r_fe   <= r_frame[0] | ~r_frame[10];
                r_byte <= r_frame[8:1];
            end
        end
    end

    // FIFO storage; contents need no reset because outputs are gated by the count
    always_ff @(posedge baud_clk) begin
        if (!rst && w_push) r_mem[r_wr] <= {r_fe, r_pe, r_byte};
    end

    // FIFO pointers, occupancy and sticky overrun (a new event beats a simultaneous clear)
    always_ff @(posedge baud_clk) begin
        if (rst) begin
            r_wr      <= '0;
            r_rd      <= '0;
            r_count   <= 4'd0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            r_count   <= r_count + {3'd0, w_push} - {3'd0, w_pop};
            r_overrun <= w_ovr_evt | (r_overrun & ~bus.err_clr);
        end
    end
endmodule

// File: tb/tb_uart_deframe.sv
// tb_uart_deframe: directed and randomized checks of uart_deframe against a queue-based reference model
module tb_uart_deframe;
    localparam int DEPTH = 4;

    logic baud_clk = 1'b0;
    logic rst      = 1'b1;
    always #5 baud_clk = ~baud_clk;

    uart_deframe_if bus0 ();
    uart_deframe_if bus1 ();

    uart_deframe #(.PARITY_ODD(0), .FIFO_DEPTH(DEPTH)) dut0 (.baud_clk(baud_clk), .rst(rst), .bus(bus0.slave));
    uart_deframe #(.PARITY_ODD(1), .FIFO_DEPTH(DEPTH)) dut1 (.baud_clk(baud_clk), .rst(rst), .bus(bus1.slave));

    assign bus1.recieved_flag = bus0.recieved_flag;
    assign bus1.data_parll    = bus0.data_parll;
    assign bus1.err_clr       = bus0.err_clr;
    assign bus1.data_ready    = bus0.data_ready;

    int vectors    = 0;
    int miscompares = 0;

    logic [9:0] q[$];
    logic [9:0] pend;
    int         stage;
    logic       prev_flag;
    logic       m_ovr;

    function automatic logic [9:0] mk(logic [10:0] f, bit odd);
        int   ones = $countones(f[9:1]);
        logic pe   = ((ones % 2) == 1) != odd;
        logic fe   = (f[0] == 1'b1) || (f[10] == 1'b0);
        return {fe, pe, f[8:1]};
    endfunction

    function automatic logic [10:0] good(logic [7:0] b);
        return {1'b1, ^b, b, 1'b0};
    endfunction

    function automatic logic [9:0] head();
        return (q.size() > 0) ? q[0] : 10'd0;
    endfunction

    // one clock: the model reacts to the inputs sampled at the edge, then outputs are sampled 1 time unit later
    task automatic cyc();
        bit rise, evt;
        int nstage;
        @(posedge baud_clk);
        if (rst) begin
            q.delete();
            stage = 0;
            prev_flag = 1'b1;
            m_ovr = 1'b0;
        end else begin
            evt  = 0;
            rise = bus0.recieved_flag && !prev_flag;
            if (q.size() > 0 && bus0.data_ready) void'(q.pop_front());
            if (stage == 2) begin
                if (q.size() < DEPTH) q.push_back(pend);
                else evt = 1;
            end
            nstage = (stage == 1) ? 2 : 0;
            if (rise && stage == 0) begin
                pend = mk(bus0.data_parll, 0);
                nstage = 1;
            end else if (rise) evt = 1;
            stage = nstage;
            m_ovr = evt | (m_ovr & ~bus0.err_clr);
            prev_flag = bus0.recieved_flag;
        end
        #1;
    endtask

    task automatic tick(int n);
        repeat (n) cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus0.recieved_flag = 1'b0;
        bus0.data_parll = 11'd0;
        bus0.err_clr = 1'b0;
        bus0.data_ready = 1'b0;
        tick(2);
        vectors++; if (bus0.data_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", bus0.data_valid); end
        vectors++; if (bus0.fifo_count !== 4'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", bus0.fifo_count); end
        vectors++; if (bus0.overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b want 0", bus0.overrun); end
        vectors++; if ({bus0.frame_err, bus0.parity_err, bus0.data_out} !== 10'd0) begin miscompares++; $display("FAIL reset_head: got %h want 000", {bus0.frame_err, bus0.parity_err, bus0.data_out}); end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_good_frame();
        bus0.data_ready = 1'b1;
        bus0.recieved_flag = 1'b1;
        bus0.data_parll = 11'h54A;
        cyc();
        bus0.recieved_flag = 1'b0;
        vectors++; if (bus0.data_valid !== 1'b0) begin miscompares++; $display("FAIL good_n1_valid: got %b want 0", bus0.data_valid); end
        cyc();
        vectors++; if (bus0.data_valid !== 1'b0) begin miscompares++; $display("FAIL good_n2_valid: got %b want 0", bus0.data_valid); end
        cyc();
        vectors++; if (bus0.data_valid !== 1'b1) begin miscompares++; $display("FAIL good_n3_valid: got %b want 1", bus0.data_valid); end
        vectors++; if ({bus0.frame_err, bus0.parity_err, bus0.data_out} !== {2'b00, 8'hA5}) begin miscompares++; $display("FAIL good_head: got %h want 0a5", {bus0.frame_err, bus0.parity_err, bus0.data_out}); end
        vectors++; if ({bus0.frame_err, bus0.parity_err, bus0.data_out} !== head()) begin miscompares++; $display("FAIL good_model: got %h want %h", {bus0.frame_err, bus0.parity_err, bus0.data_out}, head()); end
        cyc();
        vectors++; if (bus0.data_valid !== 1'b0 || bus0.fifo_count !== 4'd0) begin miscompares++; $display("FAIL good_popped: got valid %b count %0d want 0 0", bus0.data_valid, bus0.fifo_count); end
        bus0.data_ready = 1'b0;
    endtask

    task automatic test_parity();
        bus0.recieved_flag = 1'b1;
        bus0.data_parll = 11'h74A;
        cyc();
        bus0.recieved_flag = 1'b0;
        tick(3);
        vectors++; if ({bus0.frame_err, bus0.parity_err, bus0.data_out} !== {2'b01, 8'hA5}) begin miscompares++; $display("FAIL parity_even: got %h want 1a5", {bus0.frame_err, bus0.parity_err, bus0.data_out}); end
        vectors++; if ({bus1.frame_err, bus1.parity_err, bus1.data_out} !== {2'b00, 8'hA5}) begin miscompares++; $display("FAIL parity_odd: got %h want 0a5", {bus1.frame_err, bus1.parity_err, bus1.data_out}); end
        vectors++; if ({bus0.frame_err, bus0.parity_err, bus0.data_out} !== head()) begin miscompares++; $display("FAIL parity_model: got %h want %h", {bus0.frame_err, bus0.parity_err, bus0.data_out}, head()); end
        bus0.data_ready = 1'b1;
        cyc();
        bus0.data_ready = 1'b0;
    endtask

    task automatic test_framing();
        logic [10:0] frames [2] = '{11'h14A, 11'h54B};
        bus0.data_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus0.recieved_flag = 1'b1;
            bus0.data_parll = frames[i];
            cyc();
            bus0.recieved_flag = 1'b0;
            tick(3);
            vectors++; if ({bus0.frame_err, bus0.parity_err, bus0.data_out} !== {2'b10, 8'hA5}) begin miscompares++; $display("FAIL framing_%0d: got %h want 2a5", i, {bus0.frame_err, bus0.parity_err, bus0.data_out}); end
            bus0.data_ready = 1'b1;
            cyc();
            bus0.data_ready = 1'b0;
        end
    endtask

    task automatic test_fill_overrun();
        bus0.data_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus0.recieved_flag = 1'b1;
            bus0.data_parll = 11'h400 + 11'(2 * i);
            cyc();
            bus0.recieved_flag = 1'b0;
            tick(175);
            if (i == 3) begin
                vectors++; if (bus0.fifo_count !== 4'd4 || bus0.overrun !== 1'b0) begin miscompares++; $display("FAIL fill_4: got count %0d ovr %b want 4 0", bus0.fifo_count, bus0.overrun); end
            end
        end
        vectors++; if (bus0.fifo_count !== 4'd4 || bus0.overrun !== 1'b1) begin miscompares++; $display("FAIL fill_ovr: got count %0d ovr %b want 4 1", bus0.fifo_count, bus0.overrun); end
        vectors++; if (bus0.overrun !== m_ovr) begin miscompares++; $display("FAIL fill_ovr_model: got %b want %b", bus0.overrun, m_ovr); end
        bus0.data_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vectors++; if (bus0.data_out !== 8'(i)) begin miscompares++; $display("FAIL fill_pop_%0d: got %h want %h", i, bus0.data_out, 8'(i)); end
            cyc();
        end
        bus0.data_ready = 1'b0;
        vectors++; if (bus0.data_valid !== 1'b0 || bus0.overrun !== 1'b1) begin miscompares++; $display("FAIL fill_drained: got valid %b ovr %b want 0 1", bus0.data_valid, bus0.overrun); end
        bus0.err_clr = 1'b1;
        cyc();
        bus0.err_clr = 1'b0;
        vectors++; if (bus0.overrun !== 1'b0) begin miscompares++; $display("FAIL fill_clr: got %b want 0", bus0.overrun); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got[$];
        for (int c = 0; c < 60; c++) begin
            bus0.data_ready = c[0];
            bus0.recieved_flag = (c % 4 == 0) && (c / 4 < 10);
            bus0.data_parll = good(8'(c / 4));
            if (bus0.data_valid && bus0.data_ready) got.push_back(bus0.data_out);
            cyc();
            vectors++; if (bus0.fifo_count > 4'd4 || bus0.fifo_count !== 4'(q.size())) begin miscompares++; $display("FAIL b2b_count_c%0d: got %0d want %0d", c, bus0.fifo_count, q.size()); end
        end
        bus0.recieved_flag = 1'b0;
        bus0.data_ready = 1'b0;
        vectors++; if (got.size() != 10) begin miscompares++; $display("FAIL b2b_total: got %0d want 10", got.size()); end
        for (int i = 0; i < got.size() && i < 10; i++) begin
            vectors++; if (got[i] !== 8'(i)) begin miscompares++; $display("FAIL b2b_order_%0d: got %h want %h", i, got[i], 8'(i)); end
        end
    endtask

    task automatic test_held_flag();
        bus0.data_ready = 1'b0;
        bus0.recieved_flag = 1'b1;
        bus0.data_parll = good(8'h81);
        tick(3);
        bus0.recieved_flag = 1'b0;
        tick(4);
        vectors++; if (bus0.fifo_count !== 4'd1 || bus0.data_out !== 8'h81) begin miscompares++; $display("FAIL held_flag: got count %0d data %h want 1 81", bus0.fifo_count, bus0.data_out); end
        bus0.data_ready = 1'b1;
        cyc();
        bus0.data_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus0.data_ready = 1'b0;
        bus0.recieved_flag = 1'b1;
        bus0.data_parll = good(8'h5A);
        cyc();
        bus0.recieved_flag = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        tick(4);
        vectors++; if (bus0.fifo_count !== 4'd0 || bus0.data_valid !== 1'b0) begin miscompares++; $display("FAIL rst_check: got count %0d valid %b want 0 0", bus0.fifo_count, bus0.data_valid); end
        rst = 1'b1;
        bus0.recieved_flag = 1'b1;
        bus0.data_parll = good(8'h3C);
        cyc();
        rst = 1'b0;
        tick(5);
        vectors++; if (bus0.fifo_count !== 4'd0) begin miscompares++; $display("FAIL rst_flag_high: got count %0d want 0", bus0.fifo_count); end
        bus0.recieved_flag = 1'b0;
        cyc();
        bus0.recieved_flag = 1'b1;
        cyc();
        bus0.recieved_flag = 1'b0;
        tick(3);
        vectors++; if (bus0.fifo_count !== 4'd1 || bus0.data_out !== 8'h3C) begin miscompares++; $display("FAIL rst_rearm: got count %0d data %h want 1 3c", bus0.fifo_count, bus0.data_out); end
        bus0.data_ready = 1'b1;
        cyc();
        bus0.data_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            bus0.data_ready = ($urandom_range(0, 2) == 0);
            bus0.recieved_flag = ($urandom_range(0, 4) == 0);
            bus0.data_parll = 11'($urandom);
            bus0.err_clr = ($urandom_range(0, 15) == 0);
            cyc();
            vectors++; if (bus0.data_valid !== (q.size() > 0) || bus0.fifo_count !== 4'(q.size())) begin miscompares++; $display("FAIL rand_count_c%0d: got valid %b count %0d want count %0d", c, bus0.data_valid, bus0.fifo_count, q.size()); end
            vectors++; if ({bus0.frame_err, bus0.parity_err, bus0.data_out} !== head()) begin miscompares++; $display("FAIL rand_head_c%0d: got %h want %h", c, {bus0.frame_err, bus0.parity_err, bus0.data_out}, head()); end
            vectors++; if (bus0.overrun !== m_ovr) begin miscompares++; $display("FAIL rand_ovr_c%0d: got %b want %b", c, bus0.overrun, m_ovr); end
        end
        bus0.recieved_flag = 1'b0;
        bus0.err_clr = 1'b0;
        bus0.data_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity();
        test_framing();
        test_fill_overrun();
        test_back_to_back();
        test_held_flag();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
